// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single DataMemory port of the core between two requesters:
//   requester 0 : core load/store path (fixed high priority)
//   requester 1 : DMA / debug loader   (protected by an anti-starvation counter)
//
// Each access runs accept -> memory phase -> response, with exactly one
// transaction in flight. Request fields are captured at accept, so a requester
// may change them freely once its ready has been seen.
//
// Ports
//   CLK, resetl                     clock (rising edge), async active-low reset
//   reqN_valid/write/addr/wdata     request from requester N (N = 0, 1)
//   reqN_ready                      request accepted this cycle when valid && ready
//   rspN_valid                      one-cycle completion pulse to requester N
//   rspN_rdata                      load data (0 for stores), held until the
//                                   next response to the same requester
//   mem_addr/mem_wdata              DataMemory Address / WriteData
//   mem_read/mem_write              DataMemory MemoryRead / MemoryWrite
//   mem_rdata                       DataMemory ReadData
//
// Parameters
//   ADDR_W, DATA_W  address / data width
//   RD_LAT          cycles mem_read is held before mem_rdata is sampled (>= 1)
//   STARVE_LIM      consecutive requester-0 grants allowed while requester 1 waits
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 3
) (
    input  logic              CLK,
    input  logic              resetl,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Load-latency counter runs 0 .. RD_LAT-1 inside MEM.
    localparam int                LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);

    // Starvation counter saturates at STARVE_LIM.
    localparam int                STV_W    = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [STV_W-1:0]  STV_MAX  = STV_W'(STARVE_LIM);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    // Transaction latches, loaded only at accept.
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               write_q;
    logic               owner_q;     // 0 = requester 0, 1 = requester 1

    logic [LAT_W-1:0]   lat_cnt_q;
    logic [STV_W-1:0]   starve_cnt_q;

    // Per-requester response data; each holds until its own next response.
    logic [DATA_W-1:0]  rsp0_rdata_q;
    logic [DATA_W-1:0]  rsp1_rdata_q;

    logic               grant0;
    logic               grant1;
    logic               accept;
    logic               mem_done;

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        grant1     = 1'b0;
        grant0     = 1'b0;
        accept     = 1'b0;
        mem_done   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        state_d    = state_q;

        // Requester 1 wins when alone or when requester 0 has used up its
        // allowance of consecutive grants while requester 1 was waiting.
        grant1 = req1_valid && (!req0_valid || (starve_cnt_q == STV_MAX));
        grant0 = req0_valid && !grant1;

        unique case (state_q)
            ST_IDLE: begin
                // Ready is gated by resetl so it is low while reset is held,
                // even though the state register already sits in IDLE.
                req0_ready = resetl && grant0;
                req1_ready = resetl && grant1;
                accept     = req0_ready || req1_ready;
                if (accept) begin
                    state_d = ST_MEM;
                end
            end

            ST_MEM: begin
                mem_write = write_q;
                mem_read  = !write_q;
                // Stores take one cycle; loads hold mem_read for RD_LAT cycles.
                mem_done  = write_q || (lat_cnt_q == LAT_LAST);
                if (mem_done) begin
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Transaction latches, latency counter and starvation counter
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            owner_q      <= 1'b0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            if (accept) begin
                addr_q    <= grant1 ? req1_addr  : req0_addr;
                wdata_q   <= grant1 ? req1_wdata : req0_wdata;
                write_q   <= grant1 ? req1_write : req0_write;
                owner_q   <= grant1;
                lat_cnt_q <= '0;

                if (grant1) begin
                    starve_cnt_q <= '0;
                end else if (req1_valid && (starve_cnt_q != STV_MAX)) begin
                    // Requester 0 took the port while requester 1 was waiting.
                    starve_cnt_q <= starve_cnt_q + STV_W'(1);
                end
            end else if ((state_q == ST_MEM) && !mem_done) begin
                lat_cnt_q <= lat_cnt_q + LAT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response data: captured on the last memory-phase cycle, for the owner only
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else if (mem_done) begin
            if (owner_q) begin
                rsp1_rdata_q <= write_q ? '0 : mem_rdata;
            end else begin
                rsp0_rdata_q <= write_q ? '0 : mem_rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output wiring
    // -------------------------------------------------------------------------
    // The latches are cleared by reset, so address and data read 0 while
    // resetl is low; the strobes are decoded from state_q and drop with it.
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule
